leddc_tx: RTL and testbench
===========================

LEDDC_TX -- requirements
Module: leddc_tx

Interface
REQ-001 Parameter WORDS_PER_FRAME, default 512; 16-bit words sent per frame.
REQ-002 Parameter GAP_CYCLES, default 2; extra DEN-low cycles between words, legal range 0..15.
REQ-003 DCK  in  1; sole clock, all logic on rising edge.
REQ-004 rst  in  1; reset, synchronous, active-high.
REQ-005 start  in  1; frame-send request, sampled each DCK edge.
REQ-006 frame_idx  in  2; frame number, source base address = frame_idx*WORDS_PER_FRAME.
REQ-007 mem_rd  out  1; registered read strobe to the pattern memory.
REQ-008 mem_addr  out  11; registered word address, 0..2047.
REQ-009 mem_rdata  in  16; read data, valid the cycle after mem_rd is high (synchronous read).
REQ-010 DAI  out  1; registered serial data to LEDDC.
REQ-011 DEN  out  1; registered data-enable, high only while a word's bits are on DAI.
REQ-012 busy  out  1; high from start acceptance until the end of the done pulse.
REQ-013 done  out  1; one-cycle pulse marking frame completion.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, LOAD, SHIFT, GAP and DONE.
REQ-015 IDLE: start=1 SHALL be accepted, frame_idx latched, word count cleared, busy set, next state FETCH; start SHALL be ignored in every other state.
REQ-016 FETCH (1 cycle): mem_rd=1 with mem_addr = base + word count; next LOAD.
REQ-017 LOAD (1 cycle): mem_rdata SHALL be captured into a 16-bit shift register; next SHIFT.
REQ-018 SHIFT (exactly 16 cycles): DEN=1 and DAI = bit n of the word in cycle n, n=0..15 (LSB first).
REQ-019 After bit 15, if word count = WORDS_PER_FRAME-1 the next state SHALL be DONE; otherwise the word count increments and the next state is GAP, or FETCH when GAP_CYCLES=0.
REQ-020 GAP: DEN=0 for GAP_CYCLES cycles; next FETCH.
REQ-021 DEN low between words SHALL total GAP_CYCLES+2 cycles (gap, fetch, load); word period SHALL be GAP_CYCLES+18 cycles.
REQ-022 DONE (1 cycle): done=1, busy=1, DEN=0; next IDLE with busy=0.
REQ-023 Latency: for start accepted at edge k, mem_rd SHALL be high in cycle k+1 and DEN SHALL rise in cycle k+3.
REQ-024 DAI SHALL be 0 whenever DEN=0.
REQ-025 mem_rd SHALL be 0 outside FETCH.
REQ-026 mem_addr SHALL hold its last value outside FETCH.
REQ-027 Address arithmetic SHALL be 11-bit; base+count never exceeds 2047 for legal parameters, and no wrap is permitted.

Reset
REQ-028 With rst=1 at an edge, the next cycle SHALL show state IDLE, DEN=0, DAI=0, mem_rd=0, mem_addr=0, busy=0 and done=0.
REQ-029 rst SHALL override start and any in-flight word; a partially sent word is abandoned, never resumed.

Structure
REQ-030 Package leddc_pkg SHALL hold the word width (16), default WORDS_PER_FRAME, the address width (11) and the FSM state enum.
REQ-031 The 16-bit load/shift register and its 4-bit bit counter SHALL be one sub-module, leddc_tx_shreg (load, shift, serial out, last-bit flag).

Verification
REQ-032 After reset, start with frame_idx=0 and mem[a]=a -> mem_addr steps 0..511, each word is sent LSB-first over 16 DEN-high cycles, done pulses once 1 cycle after word 511 bit 15, busy falls the following cycle.
REQ-033 A memory word of 0xA5C3 -> DAI over the 16 DEN cycles = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then DEN low for 4 cycles (GAP_CYCLES=2).
REQ-034 frame_idx=3 -> first mem_addr 1536, last mem_addr 2047, no wrap; frame_idx changed mid-frame has no effect.
REQ-035 start pulsed during SHIFT and during DONE -> ignored, no restart, exactly one done; start in the cycle after DONE -> a new frame begins.
REQ-036 rst asserted during bit 7 of word 10 -> the next cycle has DEN=0, DAI=0, busy=0 and mem_rd=0; a later start resends from word 0.
REQ-037 GAP_CYCLES=0 -> DEN low exactly 2 cycles between words, word period 18 cycles, frame spans 512*18-2 cycles from the first DEN rise to the done pulse.

Source files
------------

// File: rtl/leddc_pkg.sv
// LEDDC transmitter shared definitions.
// Word/address widths, frame defaults and FSM states.
package leddc_pkg;

  localparam int WORD_W  = 16;
  localparam int ADDR_W  = 11;
  localparam int BIT_W   = 4;
  localparam int WPF_DEF = 512;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    GAP,
    DONE
  } state_e;

  // Pattern-memory word address; 11-bit, never wraps for legal frames.
  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [1:0]        frame,
    input logic [ADDR_W-1:0] cnt,
    input int                wpf
  );
    return ADDR_W'(frame) * ADDR_W'(wpf) + cnt;
  endfunction

endpackage

// File: rtl/leddc_if.sv
// Pattern-memory read port of the LEDDC transmitter.
// Synchronous read: rdata is valid the cycle after mem_rd.
interface leddc_if;
  import leddc_pkg::*;

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_rdata
  );

endinterface

// File: rtl/leddc_tx_shreg.sv
// 16-bit load/shift register with bit counter.
// Serial output is registered and drops to 0 after bit 15.
module leddc_tx_shreg
  import leddc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              sout_o,
  output logic              last_o
);

  logic [WORD_W-1:0] sr_q;
  logic [BIT_W-1:0]  cnt_q;
  logic              sout_q;

  assign last_o = (cnt_q == '1);
  assign sout_o = sout_q;

  // Load a word, then shift it out LSB first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      sout_q <= 1'b0;
    end else if (load_i) begin
      sr_q   <= data_i;
      cnt_q  <= '0;
      sout_q <= data_i[0];
    end else if (shift_i) begin
      sr_q   <= sr_q >> 1;
      cnt_q  <= cnt_q + BIT_W'(1);
      sout_q <= last_o ? 1'b0 : sr_q[1];
    end
  end

endmodule

// File: rtl/leddc_tx.sv
// LEDDC serial frame transmitter.
// Fetches words from pattern memory, sends them LSB first on DAI/DEN.
module leddc_tx
  import leddc_pkg::*;
#(
  parameter int WORDS_PER_FRAME = WPF_DEF,
  parameter int GAP_CYCLES      = 2
) (
  input  logic       DCK,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] frame_idx,
  leddc_if.master    mem,
  output logic       DAI,
  output logic       DEN,
  output logic       busy,
  output logic       done
);

  localparam logic [ADDR_W-1:0] LAST_W =
    ADDR_W'(WORDS_PER_FRAME - 1);
  localparam logic [3:0] GAP_INIT =
    4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [1:0]        frame_q, frame_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [3:0]        gap_q, gap_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              den_q, den_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sh_load, sh_shift, sh_last;

  leddc_tx_shreg u_shreg (
    .clk_i   (DCK),
    .rst_i   (rst),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .data_i  (mem.mem_rdata),
    .sout_o  (DAI),
    .last_o  (sh_last)
  );

  // Next state, word/gap counters and registered-output values.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    wcnt_d   = wcnt_q;
    gap_d    = gap_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          frame_d = frame_idx;
          wcnt_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        sh_load = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        sh_shift = 1'b1;
        if (sh_last) begin
          if (wcnt_q == LAST_W) begin
            state_d = DONE;
          end else begin
            wcnt_d = wcnt_q + ADDR_W'(1);
            if (GAP_CYCLES == 0) begin
              state_d = FETCH;
            end else begin
              state_d = GAP;
              gap_d   = GAP_INIT;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = FETCH;
        else gap_d = gap_q - 4'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_d   = (state_d == FETCH);
    addr_d = rd_d ?
      word_addr(frame_d, wcnt_d, WORDS_PER_FRAME) : addr_q;
    den_d  = (state_d == SHIFT);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset abandons any frame.
  always_ff @(posedge DCK) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      wcnt_q  <= '0;
      gap_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      den_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      wcnt_q  <= wcnt_d;
      gap_q   <= gap_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      den_q   <= den_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem.mem_rd   = rd_q;
  assign mem.mem_addr = addr_q;
  assign DEN          = den_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_leddc_tx.sv
// Bench for leddc_tx: scoreboard of addresses/words,
// a latency/bit vector table and multi-cycle corner sequences.
module tb_leddc_tx;

  localparam int WPF = 512;
  localparam int GAP = 2;

  logic       DCK = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start_g0 = 1'b0;
  logic [1:0] frame_idx = 2'd0;
  logic [1:0] fidx_g0 = 2'd0;
  logic       DAI, DEN, busy, done;
  logic       DAI_g0, DEN_g0, busy_g0, done_g0;

  leddc_if mbus ();
  leddc_if mbus_g0 ();

  logic [15:0] mem [2048];
  logic [10:0] aq [$];
  logic [15:0] wq [$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic        st;
    logic [1:0]  fi;
    logic        rd;
    logic [10:0] addr;
    logic        den;
    logic        dai;
    logic        bsy;
  } vec_t;
  vec_t tbl [23];
  logic [0:15] sp = 16'b1100_0011_1010_0101;

  always #5 DCK = ~DCK;

  leddc_tx #(.WORDS_PER_FRAME(WPF), .GAP_CYCLES(GAP)) dut (
    .DCK(DCK), .rst(rst), .start(start),
    .frame_idx(frame_idx), .mem(mbus),
    .DAI(DAI), .DEN(DEN), .busy(busy), .done(done)
  );

  leddc_tx #(.WORDS_PER_FRAME(WPF), .GAP_CYCLES(0)) dut_g0 (
    .DCK(DCK), .rst(rst), .start(start_g0),
    .frame_idx(fidx_g0), .mem(mbus_g0),
    .DAI(DAI_g0), .DEN(DEN_g0), .busy(busy_g0), .done(done_g0)
  );

  always @(posedge DCK) begin
    if (mbus.mem_rd) mbus.mem_rdata <= mem[mbus.mem_addr];
    if (mbus_g0.mem_rd) mbus_g0.mem_rdata <= mem[mbus_g0.mem_addr];
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s @%0t", name, $time);
  endtask

  // Scoreboard monitor
  logic        den_p = 1'b0;
  logic        done_p = 1'b0;
  logic        mid = 1'b0;
  int          bitn = 0;
  int          low_len = 0;
  logic [15:0] acc = '0;

  always @(negedge DCK) begin
    if (rst) begin
      aq.delete();
      wq.delete();
      bitn = 0;
      low_len = 0;
      mid = 1'b0;
      den_p = 1'b0;
      done_p = 1'b0;
    end else begin
      if (!DEN) chk("dai_idle", DAI, 0);
      if (mbus.mem_rd) begin
        if (aq.size() == 0) bad("unexpected mem_rd");
        else chk("mem_addr", mbus.mem_addr, aq.pop_front());
      end
      if (DEN) begin
        if (!den_p && mid) chk("den_low_len", low_len, GAP + 2);
        if (bitn < 16) acc[bitn] = DAI;
        bitn++;
        low_len = 0;
        chk("done_spurious", done, 0);
      end else begin
        low_len++;
        if (den_p) begin
          chk("den_high_len", bitn, 16);
          if (wq.size() == 0) bad("unexpected word");
          else chk("word", acc, wq.pop_front());
          chk("done_at_end", done, wq.size() == 0);
          mid = (wq.size() != 0);
          bitn = 0;
        end else begin
          chk("done_spurious", done, 0);
        end
      end
      if (done_p) chk("busy_after_done", busy, 0);
      if (wq.size() > 0 || aq.size() > 0) chk("busy", busy, 1);
      if (done) done_cnt++;
      den_p = DEN;
      done_p = done;
    end
  end

  task automatic push_frame(input int f);
    for (int i = 0; i < WPF; i++) begin
      aq.push_back(11'(f * WPF + i));
      wq.push_back(mem[f * WPF + i]);
    end
  endtask

  task automatic send_start(input logic [1:0] f);
    @(negedge DCK);
    start = 1'b1;
    frame_idx = f;
    @(posedge DCK);
    #1 start = 1'b0;
    push_frame(int'(f));
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge DCK);
      if (done) seen = 1;
    end
    if (!seen) bad(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, rises, hi, first, low, last_rise;
    bit found, gseen;
    logic prevd;

    for (int a = 0; a < 2048; a++) begin
      if (a < 512) mem[a] = 16'(a);
      else mem[a] = 16'(a * 40503) ^ 16'h3C5A;
    end
    mem[1536] = 16'hA5C3;

    for (int j = 0; j < 23; j++)
      tbl[j] = '{st: 1'b0, fi: 2'd3, rd: 1'b0, addr: 11'd1536,
                 den: 1'b0, dai: 1'b0, bsy: 1'b1};
    tbl[0].rd = 1'b1;
    for (int n = 0; n < 16; n++) begin
      tbl[2 + n].den = 1'b1;
      tbl[2 + n].dai = sp[n];
    end
    for (int j = 8; j < 23; j++) tbl[j].fi = 2'd1;
    tbl[5].st = 1'b1;
    tbl[20].rd = 1'b1;
    for (int j = 20; j < 23; j++) tbl[j].addr = 11'd1537;
    tbl[22].den = 1'b1;
    tbl[22].dai = mem[1537][0];

    // Reset values
    repeat (3) @(posedge DCK);
    @(negedge DCK);
    chk("rst_den", DEN, 0);
    chk("rst_dai", DAI, 0);
    chk("rst_rd", mbus.mem_rd, 0);
    chk("rst_addr", mbus.mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge DCK);
    #1 rst = 1'b0;

    // Full frame 0
    d0 = done_cnt;
    send_start(2'd0);
    wait_done(11000, "f0_done_timeout");
    @(negedge DCK);
    chk("f0_busy_low", busy, 0);
    chk("f0_one_done", done_cnt - d0, 1);

    // Frame 3: latency, A5C3 bits, gap, ignored start/frame_idx
    d0 = done_cnt;
    send_start(2'd3);
    for (int j = 0; j < 23; j++) begin
      @(negedge DCK);
      chk("v_rd", mbus.mem_rd, tbl[j].rd);
      chk("v_addr", mbus.mem_addr, tbl[j].addr);
      chk("v_den", DEN, tbl[j].den);
      chk("v_dai", DAI, tbl[j].dai);
      chk("v_busy", busy, tbl[j].bsy);
      start = tbl[j].st;
      frame_idx = tbl[j].fi;
    end
    start = 1'b0;
    wait_done(11000, "f3_done_timeout");
    start = 1'b1;
    frame_idx = 2'd0;
    @(posedge DCK);
    @(negedge DCK);
    chk("done_start_busy", busy, 0);
    chk("done_start_rd", mbus.mem_rd, 0);
    @(posedge DCK);
    #1 start = 1'b0;
    push_frame(0);
    @(negedge DCK);
    chk("restart_rd", mbus.mem_rd, 1);
    chk("restart_addr", mbus.mem_addr, 0);
    chk("f3_one_done", done_cnt - d0, 1);

    // Reset during bit 7 of word 10
    rises = 0;
    hi = 0;
    found = 0;
    prevd = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge DCK);
      if (DEN && !prevd) begin
        rises++;
        hi = 0;
      end
      if (DEN) hi++;
      if (rises == 11 && hi == 8) found = 1;
      prevd = DEN;
    end
    if (!found) bad("word10_timeout");
    chk("w10_bit7", DAI, mem[10][7]);
    rst = 1'b1;
    @(posedge DCK);
    @(negedge DCK);
    chk("mid_rst_den", DEN, 0);
    chk("mid_rst_dai", DAI, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd", mbus.mem_rd, 0);
    chk("mid_rst_addr", mbus.mem_addr, 0);
    chk("mid_rst_done", done, 0);
    @(posedge DCK);
    #1 rst = 1'b0;
    d0 = done_cnt;
    send_start(2'd0);
    wait_done(11000, "resend_done_timeout");
    @(negedge DCK);
    chk("resend_one_done", done_cnt - d0, 1);

    // GAP_CYCLES = 0 instance
    @(negedge DCK);
    start_g0 = 1'b1;
    fidx_g0 = 2'd0;
    @(posedge DCK);
    #1 start_g0 = 1'b0;
    first = -1;
    rises = 0;
    low = 0;
    last_rise = 0;
    gseen = 0;
    prevd = 1'b0;
    for (int c = 0; c < 12000 && !gseen; c++) begin
      @(negedge DCK);
      if (!DEN_g0 && DAI_g0) chk("g0_dai_idle", DAI_g0, 0);
      if (DEN_g0 && !prevd) begin
        if (rises > 0) begin
          chk("g0_low", low, 2);
          chk("g0_period", c - last_rise, 18);
        end else begin
          first = c;
          chk("g0_latency", first, 2);
        end
        rises++;
        last_rise = c;
      end
      if (DEN_g0) low = 0;
      else low++;
      if (done_g0) begin
        gseen = 1;
        chk("g0_span", c - first, WPF * 18 - 2);
        chk("g0_busy", busy_g0, 1);
      end
      prevd = DEN_g0;
    end
    if (!gseen) bad("g0_done_timeout");
    chk("g0_words", rises, WPF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
